// File: rtl/frame_parser_pp.sv
// Frame parser with ping-pong payload slots: header hunt, LEN/CHSEL/CRC-16 checks, valid/ready drain.
// Optional saturating statistics counters are enabled by defining FRAME_STATS_EN.
module frame_parser_pp #(
    parameter int          NUM_CH    = 8,
    parameter int          MAX_WORDS = 16,
    parameter logic [15:0] HEADER    = 16'hE0E0,
    parameter int          TIMEOUT   = 64,
    parameter logic [15:0] CRC_POLY  = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [15:0]       data_in,
    input  logic              data_vld_in,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [NUM_CH-1:0] out_ch_mask,
    output logic              crc_err,
    output logic              frame_drop,
    output logic              frame_abort,
    output logic              busy
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]       stat_good,
    output logic [15:0]       stat_crc_err,
    output logic [15:0]       stat_lost
`endif
);

    localparam int IW = $clog2(MAX_WORDS);
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [TW-1:0] ONE_T   = TW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   MAX_W16 = 16'(MAX_WORDS);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_CHSEL, S_PAYLOAD, S_CRC} state_t;

    state_t            r_state;
    logic [15:0]       r_crc;
    logic [TW-1:0]     r_toCnt;
    logic [LW-1:0]     r_curLen;
    logic [LW-1:0]     r_wrIdx;
    logic              r_wrSlot;
    logic [1:0]        r_slotFull;
    logic [LW-1:0]     r_slotLen  [2];
    logic [NUM_CH-1:0] r_slotMask [2];
    logic [15:0]       r_mem      [2][MAX_WORDS];
    logic              r_rdSlot;
    logic [LW-1:0]     r_rdIdx;
    logic              r_waitVld;
    logic              r_waitSlot;

    logic          w_hs;
    logic          w_hsLast;
    logic [1:0]    w_freeMask;
    logic          w_newSlot;
    logic          w_commit;
    logic          w_timeout;
    logic          w_startGo;
    logic          w_startSlot;
    logic [LW-1:0] w_nextIdx;
    logic          w_lenOk;

    function automatic logic [15:0] crcNext(input logic [15:0] c, input logic [15:0] d);
        logic fb;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    // A slot finishing its last handshake this cycle is already free for an incoming header.
    always_comb begin
        w_hs       = out_valid & out_ready;
        w_hsLast   = w_hs & out_last;
        w_freeMask = ~r_slotFull;
        if (w_hsLast) w_freeMask[r_rdSlot] = 1'b1;
        w_newSlot   = ~w_freeMask[0];
        w_commit    = (r_state == S_CRC) && data_vld_in && (data_in == r_crc);
        w_timeout   = (r_state != S_HUNT) && !data_vld_in && (r_toCnt == TO_LAST);
        w_startGo   = r_waitVld | w_commit;
        w_startSlot = r_waitVld ? r_waitSlot : r_wrSlot;
        w_nextIdx   = r_rdIdx + ONE_L;
        w_lenOk     = (data_in != 16'd0) && (data_in <= MAX_W16);
    end

    assign busy = (r_state != S_HUNT);

    always_ff @(posedge clk_in) begin
        if (r_state == S_PAYLOAD && data_vld_in)
            r_mem[r_wrSlot][r_wrIdx[IW-1:0]] <= data_in;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_crc         <= CRC_INIT;
            r_toCnt       <= '0;
            r_curLen      <= '0;
            r_wrIdx       <= '0;
            r_wrSlot      <= 1'b0;
            r_slotFull    <= '0;
            r_slotLen[0]  <= '0;
            r_slotLen[1]  <= '0;
            r_slotMask[0] <= '0;
            r_slotMask[1] <= '0;
            r_rdSlot      <= 1'b0;
            r_rdIdx       <= '0;
            r_waitVld     <= 1'b0;
            r_waitSlot    <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_ch_mask   <= '0;
            crc_err       <= 1'b0;
            frame_drop    <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            crc_err     <= 1'b0;
            frame_drop  <= 1'b0;
            frame_abort <= 1'b0;
            if (w_hsLast) r_slotFull[r_rdSlot] <= 1'b0;

            if (data_vld_in)            r_toCnt <= '0;
            else if (r_state != S_HUNT) r_toCnt <= r_toCnt + ONE_T;

            // Later assignments win, so a claim or release below overrides the drain release above.
            if (w_timeout) begin
                frame_abort          <= 1'b1;
                r_slotFull[r_wrSlot] <= 1'b0;
                r_toCnt              <= '0;
                r_state              <= S_HUNT;
            end else if (data_vld_in) begin
                case (r_state)
                    S_HUNT: begin
                        if (data_in == HEADER) begin
                            if (|w_freeMask) begin
                                r_slotFull[w_newSlot] <= 1'b1;
                                r_wrSlot              <= w_newSlot;
                                r_crc                 <= CRC_INIT;
                                r_wrIdx               <= '0;
                                r_state               <= S_LEN;
                            end else begin
                                frame_drop <= 1'b1;
                            end
                        end
                    end
                    S_LEN: begin
                        if (w_lenOk) begin
                            r_curLen            <= data_in[LW-1:0];
                            r_slotLen[r_wrSlot] <= data_in[LW-1:0];
                            r_crc               <= crcNext(r_crc, data_in);
                            r_state             <= S_CHSEL;
                        end else begin
                            frame_abort          <= 1'b1;
                            r_slotFull[r_wrSlot] <= 1'b0;
                            r_state              <= S_HUNT;
                        end
                    end
                    S_CHSEL: begin
                        if (|data_in[NUM_CH-1:0]) begin
                            r_slotMask[r_wrSlot] <= data_in[NUM_CH-1:0];
                            r_crc                <= crcNext(r_crc, data_in);
                            r_state              <= S_PAYLOAD;
                        end else begin
                            frame_abort          <= 1'b1;
                            r_slotFull[r_wrSlot] <= 1'b0;
                            r_state              <= S_HUNT;
                        end
                    end
                    S_PAYLOAD: begin
                        r_crc   <= crcNext(r_crc, data_in);
                        r_wrIdx <= r_wrIdx + ONE_L;
                        if (r_wrIdx == r_curLen - ONE_L) r_state <= S_CRC;
                    end
                    S_CRC: begin
                        if (!w_commit) begin
                            crc_err              <= 1'b1;
                            r_slotFull[r_wrSlot] <= 1'b0;
                        end
                        r_state <= S_HUNT;
                    end
                    default: r_state <= S_HUNT;
                endcase
            end

            // Drain: start a new frame when idle or right on the previous frame's last handshake.
            if (!out_valid || w_hsLast) begin
                if (w_startGo) begin
                    out_valid   <= 1'b1;
                    out_data    <= r_mem[w_startSlot][0];
                    out_last    <= (r_slotLen[w_startSlot] == ONE_L);
                    out_ch_mask <= r_slotMask[w_startSlot];
                    r_rdSlot    <= w_startSlot;
                    r_rdIdx     <= '0;
                    r_waitVld   <= r_waitVld & w_commit;
                    r_waitSlot  <= r_wrSlot;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else begin
                if (w_hs) begin
                    r_rdIdx  <= w_nextIdx;
                    out_data <= r_mem[r_rdSlot][w_nextIdx[IW-1:0]];
                    out_last <= (w_nextIdx == r_slotLen[r_rdSlot] - ONE_L);
                end
                if (w_commit) begin
                    r_waitVld  <= 1'b1;
                    r_waitSlot <= r_wrSlot;
                end
            end
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            stat_good    <= '0;
            stat_crc_err <= '0;
            stat_lost    <= '0;
        end else begin
            if (w_commit && stat_good != 16'hFFFF)                 stat_good    <= stat_good + 16'd1;
            if (crc_err && stat_crc_err != 16'hFFFF)               stat_crc_err <= stat_crc_err + 16'd1;
            if ((frame_drop || frame_abort) && stat_lost != 16'hFFFF) stat_lost <= stat_lost + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_parser_pp.sv
// Self-checking bench for frame_parser_pp: scoreboard of expected drain words plus pulse/timing checks.
// Stats counters are checked when FRAME_STATS_EN is defined.
module tb_frame_parser_pp;

    localparam logic [15:0] HDR  = 16'hE0E0;
    localparam logic [15:0] POLY = 16'h1021;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_vld_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  out_ch_mask;
    logic        crc_err;
    logic        frame_drop;
    logic        frame_abort;
    logic        busy;
`ifdef FRAME_STATS_EN
    logic [15:0] stat_good;
    logic [15:0] stat_crc_err;
    logic [15:0] stat_lost;
`endif

    int nChecks = 0;
    int nErrors = 0;
    int expGood = 0;
    int expCrc  = 0;
    int expLost = 0;

    logic [24:0] sbq[$];
    logic [15:0] pl [0:255];
    logic        stall = 1'b0;
    logic [31:0] holdWord;

    frame_parser_pp dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_vld_in (data_vld_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_ch_mask (out_ch_mask),
        .crc_err     (crc_err),
        .frame_drop  (frame_drop),
        .frame_abort (frame_abort),
        .busy        (busy)
`ifdef FRAME_STATS_EN
        ,
        .stat_good    (stat_good),
        .stat_crc_err (stat_crc_err),
        .stat_lost    (stat_lost)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Word-at-a-time CRC: fold the word in, then 16 polynomial shifts.
    function automatic logic [15:0] tbCrc(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        r = c ^ w;
        for (int b = 0; b < 16; b++) r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    task automatic applyStimulus(input logic [15:0] w);
        data_in     = w;
        data_vld_in = 1'b1;
        @(posedge clk_in);
        #1;
        data_vld_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic fillPayload(input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) pl[i] = base + 16'(i);
    endtask

    task automatic sendFrame(input int len, input logic [15:0] chsel, input logic [15:0] crcXor, input bit expectOut);
        logic [15:0] c;
        logic [15:0] lw;
        c  = 16'hFFFF;
        lw = len[15:0];
        applyStimulus(HDR);
        applyStimulus(lw);
        c = tbCrc(c, lw);
        applyStimulus(chsel);
        c = tbCrc(c, chsel);
        for (int i = 0; i < len; i++) begin
            applyStimulus(pl[i]);
            c = tbCrc(c, pl[i]);
            if (expectOut) sbq.push_back({(i == len - 1), chsel[7:0], pl[i]});
        end
        applyStimulus(c ^ crcXor);
    endtask

    task automatic waitDrain(input int budget, output int used);
        used = 0;
        while (sbq.size() != 0 && used < budget) begin
            @(posedge clk_in);
            used++;
        end
        if (used != 0) #1;
        if (sbq.size() != 0) checkOutput("drain_timeout", sbq.size(), 0);
    endtask

    // Scoreboard monitor: pops on each handshake and checks outputs hold while stalled.
    always @(negedge clk_in) begin
        logic [24:0] e;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) checkOutput("hold", {out_valid, out_last, out_ch_mask, out_data}, holdWord);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_out", {out_valid, out_last, out_ch_mask, out_data}, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("drain", {out_last, out_ch_mask, out_data}, e);
                end
            end
            stall    = out_valid && !out_ready;
            holdWord = {out_valid, out_last, out_ch_mask, out_data};
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  used;
        bit  sawValid;
        rst_n       = 1'b0;
        data_in     = '0;
        data_vld_in = 1'b0;
        out_ready   = 1'b0;
        idle(3);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pulses", {crc_err, frame_drop, frame_abort}, 0);
        checkOutput("rst_out", {out_last, out_ch_mask, out_data}, 0);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] test 1: good frame");
        out_ready = 1'b1;
        pl[0] = 16'h1111; pl[1] = 16'h2222; pl[2] = 16'h3333;
        sendFrame(3, 16'h0005, 16'h0000, 1'b1);
        expGood++;
        checkOutput("t1_valid_after_crc", out_valid, 1);
        checkOutput("t1_no_crc_err", crc_err, 0);
        waitDrain(50, used);

        $display("[TB] test 2: CRC error");
        sendFrame(3, 16'h0005, 16'h0001, 1'b0);
        expCrc++;
        checkOutput("t2_crc_err_pulse", crc_err, 1);
        checkOutput("t2_no_valid", out_valid, 0);
        idle(1);
        checkOutput("t2_pulse_one_cycle", crc_err, 0);
        fillPayload(16'h0A00, 2);
        sendFrame(2, 16'h0003, 16'h0000, 1'b1);
        expGood++;
        waitDrain(50, used);

        $display("[TB] test 3: back-to-back frames with backpressure");
        out_ready = 1'b0;
        fillPayload(16'h1000, 16);
        sendFrame(16, 16'h0011, 16'h0000, 1'b1);
        fillPayload(16'h2000, 16);
        sendFrame(16, 16'h0022, 16'h0000, 1'b1);
        expGood += 2;
        applyStimulus(HDR);
        expLost++;
        checkOutput("t3_drop_pulse", frame_drop, 1);
        checkOutput("t3_drop_not_busy", busy, 0);
        idle(3);
        out_ready = 1'b1;
        waitDrain(100, used);
        checkOutput("t3_nogap_cycles", used, 32);

        $display("[TB] test 4: bad fields");
        applyStimulus(HDR);
        applyStimulus(16'h0000);
        expLost++;
        checkOutput("t4_len0_abort", frame_abort, 1);
        checkOutput("t4_len0_busy", busy, 0);
        applyStimulus(HDR);
        applyStimulus(16'h0011);
        expLost++;
        checkOutput("t4_len17_abort", frame_abort, 1);
        checkOutput("t4_len17_busy", busy, 0);
        applyStimulus(HDR);
        applyStimulus(16'h0002);
        applyStimulus(16'h0100);
        expLost++;
        checkOutput("t4_chsel_abort", frame_abort, 1);
        checkOutput("t4_chsel_busy", busy, 0);
        fillPayload(16'h4000, 2);
        sendFrame(2, 16'h0081, 16'h0000, 1'b1);
        expGood++;
        waitDrain(50, used);

        $display("[TB] test 5: timeout");
        applyStimulus(HDR);
        applyStimulus(16'h0002);
        idle(63);
        checkOutput("t5_no_early_abort", frame_abort, 0);
        checkOutput("t5_busy_waiting", busy, 1);
        idle(1);
        expLost++;
        checkOutput("t5_timeout_abort", frame_abort, 1);
        checkOutput("t5_timeout_busy", busy, 0);
        fillPayload(16'h5000, 2);
        sendFrame(2, 16'h0040, 16'h0000, 1'b1);
        expGood++;
        waitDrain(50, used);

        $display("[TB] test 6: random backpressure and reset");
        out_ready = 1'b0;
        fillPayload(16'h6000, 4);
        sendFrame(4, 16'h0007, 16'h0000, 1'b1);
        expGood++;
        used = 0;
        while (sbq.size() != 0 && used < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk_in);
            #1;
            used++;
        end
        checkOutput("t6_random_drain_done", sbq.size(), 0);
        out_ready = 1'b1;
        idle(4);
`ifdef FRAME_STATS_EN
        checkOutput("stat_good", stat_good, expGood);
        checkOutput("stat_crc_err", stat_crc_err, expCrc);
        checkOutput("stat_lost", stat_lost, expLost);
`endif

        out_ready = 1'b0;
        fillPayload(16'h7000, 2);
        sendFrame(2, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(HDR);
        applyStimulus(16'h0004);
        applyStimulus(16'h0003);
        applyStimulus(16'h7100);
        applyStimulus(16'h7101);
        rst_n = 1'b0;
        #2;
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_out", {out_last, out_ch_mask, out_data}, 0);
        checkOutput("t6_rst_pulses", {crc_err, frame_drop, frame_abort}, 0);
`ifdef FRAME_STATS_EN
        checkOutput("t6_rst_stats", {stat_good | stat_crc_err | stat_lost}, 0);
`endif
        @(posedge clk_in);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sawValid  = 1'b0;
        repeat (20) begin
            @(posedge clk_in);
            #1;
            sawValid |= out_valid;
        end
        checkOutput("t6_no_stale_frame", sawValid, 0);
        fillPayload(16'h8000, 3);
        sendFrame(3, 16'h00F0, 16'h0000, 1'b1);
        checkOutput("t6_post_reset_valid", out_valid, 1);
        waitDrain(50, used);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
